// File: rtl/regfile_write_arbiter_if.sv
// Write-side bundle between two requesters, the clear control and the register file write port.
// Arbiter uses the slave modport; requesters/register file side use master.
interface regfile_write_arbiter_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 5
);
    logic              init_start;
    logic              init_busy;
    logic              req0_valid;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_data;
    logic              req0_ready;
    logic              req1_valid;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_data;
    logic              req1_ready;
    logic [ADDR_W-1:0] rf_Rw;
    logic [DATA_W-1:0] rf_busW;
    logic              rf_wrEn;

    modport master (
        output init_start, req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
        input  init_busy, req0_ready, req1_ready, rf_Rw, rf_busW, rf_wrEn
    );

    modport slave (
        input  init_start, req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
        output init_busy, req0_ready, req1_ready, rf_Rw, rf_busW, rf_wrEn
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin owner of the register file write port, with a zero-fill clear sequence.
// Optional REGFILE_R0_ZERO_EN: run-time writes to address 0 are accepted but suppressed.
module regfile_write_arbiter #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NUM_REGS = 32
) (
    input logic                   clk,
    input logic                   rst,
    regfile_write_arbiter_if.slave bus
);
    localparam logic [0:0]        StClear  = 1'b0;
    localparam logic [0:0]        StRun    = 1'b1;
    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(NUM_REGS - 1);

    logic [0:0]        state, stateNext;
    logic [ADDR_W-1:0] clearCnt, clearCntNext;
    logic              rrPtr, rrPtrNext;
    logic [ADDR_W-1:0] rfRw, rfRwNext;
    logic [DATA_W-1:0] rfBusW, rfBusWNext;
    logic              rfWrEn, rfWrEnNext;

    logic              bothValid;
    logic              anyValid;
    logic              grantSel;
    logic              xfer;
    logic [ADDR_W-1:0] xferAddr;
    logic [DATA_W-1:0] xferData;
    logic              dropWrite;

    always_comb begin
        bothValid = bus.req0_valid && bus.req1_valid;
        anyValid  = bus.req0_valid || bus.req1_valid;
        // Contention follows the pointer; otherwise the lone valid requester wins.
        grantSel  = bothValid ? rrPtr : bus.req1_valid;
    end

    assign xfer     = (state == StRun) && !bus.init_start && anyValid;
    assign xferAddr = grantSel ? bus.req1_addr : bus.req0_addr;
    assign xferData = grantSel ? bus.req1_data : bus.req0_data;

`ifdef REGFILE_R0_ZERO_EN
    assign dropWrite = (xferAddr == '0);
`else
    assign dropWrite = 1'b0;
`endif

    assign bus.req0_ready = xfer && !grantSel;
    assign bus.req1_ready = xfer && grantSel;
    assign bus.init_busy  = (state == StClear);
    assign bus.rf_Rw      = rfRw;
    assign bus.rf_busW    = rfBusW;
    assign bus.rf_wrEn    = rfWrEn;

    always_comb begin
        stateNext    = state;
        clearCntNext = clearCnt;
        rrPtrNext    = rrPtr;
        rfRwNext     = rfRw;
        rfBusWNext   = rfBusW;
        rfWrEnNext   = 1'b0;
        case (state)
            StClear: begin
                rfRwNext   = clearCnt;
                rfBusWNext = '0;
                rfWrEnNext = 1'b1;
                if (clearCnt == LastAddr) begin
                    stateNext    = StRun;
                    clearCntNext = '0;
                end else begin
                    clearCntNext = clearCnt + ADDR_W'(1);
                end
            end
            default: begin
                if (bus.init_start) begin
                    stateNext    = StClear;
                    clearCntNext = '0;
                end else if (xfer) begin
                    if (!dropWrite) begin
                        rfRwNext   = xferAddr;
                        rfBusWNext = xferData;
                        rfWrEnNext = 1'b1;
                    end
                    if (bothValid) begin
                        rrPtrNext = !grantSel;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= StClear;
            clearCnt <= '0;
            rrPtr    <= 1'b0;
            rfRw     <= '0;
            rfBusW   <= '0;
            rfWrEn   <= 1'b0;
        end else begin
            state    <= stateNext;
            clearCnt <= clearCntNext;
            rrPtr    <= rrPtrNext;
            rfRw     <= rfRwNext;
            rfBusW   <= rfBusWNext;
            rfWrEn   <= rfWrEnNext;
        end
    end
endmodule
